// File: rtl/enc_rd_core.sv
// enc_rd_core: 8b/10b code-group selection stage placed after the 5B/6B
// classifier. Looks up the 6B and 4B sub-blocks for the incoming byte,
// selects the RD- or RD+ form of each sub-block from the registered running
// disparity (RD), and presents the 10-bit group in a single output register.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   input handshake (byte, K flag, classifier vector L)
//   data_in[7:0]        {H,G,F,E,D,C,B,A}, A = bit 0
//   K                   control-character request
//   L[5:0]              {L40,L31,L22,L13,L04,K} from the classifier
//   data_out[9:0]       {a,b,c,d,e,i,f,g,h,j}, bit 9 sent first
//   out_valid/out_ready output handshake toward the serializer
//   rd_out              RD after the word in data_out (0 = RD-, 1 = RD+)
//   k_err               K requested for a non-existent control code
//   l_err               L inconsistent with data_in or with K
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. in_ready = ~out_valid | out_ready, so the output
// register can be drained and refilled on the same edge without a bubble;
// while out_valid & ~out_ready all outputs hold.
module enc_rd_core #(
  parameter logic RD_INIT = 1'b0,
  parameter bit   CHECK_L = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data_in,
  input  logic       K,
  input  logic [5:0] L,
  output logic [9:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       rd_out,
  output logic       k_err,
  output logic       l_err
);

  typedef enum logic {RDN = 1'b0, RDP = 1'b1} rd_state_t;

  rd_state_t  rd_q, rd_d;
  logic       out_valid_q, out_valid_d;
  logic [9:0] data_q, data_d;
  logic       k_err_q, k_err_d;
  logic       l_err_q, l_err_d;

  logic [4:0] x;
  logic [2:0] y;
  logic       k_ok, k28;
  logic [5:0] code6_n, code6;
  logic       flip6, rd_mid;
  logic       alt7;
  logic [3:0] code4_n, code4;
  logic       flip4, rd_new;
  logic [2:0] ones_lo;
  logic [4:0] l_exp;
  logic       k_err_w, l_err_w;
  logic       accept;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    x = data_in[4:0];
    y = data_in[7:5];
    k_ok = K & ((x == 5'd28) |
                ((y == 3'd7) & ((x == 5'd23) | (x == 5'd27) | (x == 5'd29) | (x == 5'd30))));
    k28 = k_ok & (x == 5'd28);

    // RD- form of the 6B sub-block; the RD+ form is its complement when
    // unbalanced (and for D.7, whose balanced pair still alternates).
    code6_n = 6'b000000;
    case (x)
      5'd0:  code6_n = 6'b100111;
      5'd1:  code6_n = 6'b011101;
      5'd2:  code6_n = 6'b101101;
      5'd3:  code6_n = 6'b110001;
      5'd4:  code6_n = 6'b110101;
      5'd5:  code6_n = 6'b101001;
      5'd6:  code6_n = 6'b011001;
      5'd7:  code6_n = 6'b111000;
      5'd8:  code6_n = 6'b111001;
      5'd9:  code6_n = 6'b100101;
      5'd10: code6_n = 6'b010101;
      5'd11: code6_n = 6'b110100;
      5'd12: code6_n = 6'b001101;
      5'd13: code6_n = 6'b101100;
      5'd14: code6_n = 6'b011100;
      5'd15: code6_n = 6'b010111;
      5'd16: code6_n = 6'b011011;
      5'd17: code6_n = 6'b100011;
      5'd18: code6_n = 6'b010011;
      5'd19: code6_n = 6'b110010;
      5'd20: code6_n = 6'b001011;
      5'd21: code6_n = 6'b101010;
      5'd22: code6_n = 6'b011010;
      5'd23: code6_n = 6'b111010;
      5'd24: code6_n = 6'b110011;
      5'd25: code6_n = 6'b100110;
      5'd26: code6_n = 6'b010110;
      5'd27: code6_n = 6'b110110;
      5'd28: code6_n = 6'b001110;
      5'd29: code6_n = 6'b101110;
      5'd30: code6_n = 6'b011110;
      default: code6_n = 6'b101011;
    endcase
    if (k28) code6_n = 6'b001111;

    // 000111/111000 are balanced, so D.7 never moves RD.
    flip6  = ($countones(code6_n) != 3);
    code6  = ((rd_q == RDP) && (flip6 || ((x == 5'd7) && !k28))) ? ~code6_n : code6_n;
    rd_mid = (rd_q == RDP) ^ flip6;

    // A7 avoids a run of five equal bits across the sub-block boundary.
    alt7 = k_ok |
           (!rd_mid & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20))) |
           ( rd_mid & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14)));

    // RD- form of the 4B sub-block. The K column differs from data for
    // y = 1, 2, 5, 6 (keeps the comma property of K28.y) and always uses
    // the complement at RD+.
    code4_n = 4'b0000;
    if (k_ok) begin
      case (y)
        3'd0: code4_n = 4'b1011;
        3'd1: code4_n = 4'b0110;
        3'd2: code4_n = 4'b1010;
        3'd3: code4_n = 4'b1100;
        3'd4: code4_n = 4'b1101;
        3'd5: code4_n = 4'b0101;
        3'd6: code4_n = 4'b1001;
        default: code4_n = 4'b0111;
      endcase
    end else begin
      case (y)
        3'd0: code4_n = 4'b1011;
        3'd1: code4_n = 4'b1001;
        3'd2: code4_n = 4'b0101;
        3'd3: code4_n = 4'b1100;
        3'd4: code4_n = 4'b1101;
        3'd5: code4_n = 4'b1010;
        3'd6: code4_n = 4'b0110;
        default: code4_n = alt7 ? 4'b0111 : 4'b1110;
      endcase
    end

    flip4  = ($countones(code4_n) != 2);
    code4  = (rd_mid && (flip4 || (y == 3'd3) || k_ok)) ? ~code4_n : code4_n;
    rd_new = rd_mid ^ flip4;

    k_err_w = K & ~k_ok;

    // L[5:1] must be the one-hot position of the popcount of data_in[3:0].
    ones_lo = {2'b00, data_in[0]} + {2'b00, data_in[1]} +
              {2'b00, data_in[2]} + {2'b00, data_in[3]};
    l_exp   = 5'b00001 << ones_lo;
    l_err_w = CHECK_L ? ((L[5:1] != l_exp) | (L[0] != K)) : 1'b0;

    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    k_err_d     = k_err_q;
    l_err_d     = l_err_q;
    if (accept) begin
      rd_d        = rd_new ? RDP : RDN;
      out_valid_d = 1'b1;
      data_d      = {code6, code4};
      k_err_d     = k_err_w;
      l_err_d     = l_err_w;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q        <= rd_state_t'(RD_INIT);
      out_valid_q <= 1'b0;
      data_q      <= 10'd0;
      k_err_q     <= 1'b0;
      l_err_q     <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      k_err_q     <= k_err_d;
      l_err_q     <= l_err_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = out_valid_q;
  assign rd_out    = (rd_q == RDP);
  assign k_err     = k_err_q;
  assign l_err     = l_err_q;

endmodule
